// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Issues one instruction-memory request
//               per PC value, pulses pc_advance_o to let the PC register load
//               its next value, and queues returned instructions (with the
//               address they came from) in a small circular buffer for decode.
//               A flush drops buffered entries and any in-flight response.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int ADDR_W    = 16,
  parameter int INSTR_W   = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               pc_advance_o,
  input  logic               flush_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               instr_ready_i
);

  localparam int c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // free to issue a request
    WAIT = 2'd1,  // one request outstanding
    DROP = 2'd2   // outstanding request was flushed, discard its response
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_PTR_W-1:0]  r_rptr;
  logic [c_PTR_W-1:0]  r_wptr;
  logic [INSTR_W-1:0]  r_buf_instr [BUF_DEPTH];
  logic [ADDR_W-1:0]   r_buf_pc    [BUF_DEPTH];

  // Next-state and issue/push decode. The outstanding request reserves a
  // buffer slot, so IDLE only needs count < depth. Issue is gated by rst_n so
  // the combinational request stays low while reset is asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n && !flush_i && (r_count < c_DEPTH)) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack_i) begin
          w_push      = !flush_i;
          w_state_nxt = IDLE;
        end else if (flush_i) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_ack_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign imem_req_o    = w_issue;
  assign pc_advance_o  = w_issue;
  assign imem_addr_o   = w_issue ? pc_i : '0;
  assign instr_valid_o = (r_count != '0);
  assign instr_o       = r_buf_instr[r_rptr];
  assign instr_pc_o    = r_buf_pc[r_rptr];
  // A flush cancels any pop in the same cycle.
  assign w_pop         = instr_valid_o && instr_ready_i && !flush_i;

  // FSM state register and latch of the address of the request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_req_addr <= pc_i;
      end
    end
  end

  // Circular instruction buffer: pointers/count, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
    end else if (flush_i) begin
      r_count <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage write; cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_instr[i] <= '0;
        r_buf_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_buf_instr[r_wptr] <= imem_rdata_i;
      r_buf_pc[r_wptr]    <= r_req_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. A behavioural PC register
//               and instruction memory (latency N, data 0xA000+addr) surround
//               the DUT; per-cycle expectations are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_i;
  logic        pc_advance_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i;
  logic [15:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [15:0] instr_o;
  logic [15:0] instr_pc_o;
  logic        instr_ready_i;

  int tests = 0;
  int fails = 0;

  // Memory model state
  int          mem_lat;
  bit          mem_busy;
  int          mem_cnt;
  logic [15:0] mem_paddr;
  bit          use_ovr;
  logic [15:0] ovr_data;

  instr_fetch #(.ADDR_W(16), .INSTR_W(16), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_i         (pc_i),
    .pc_advance_o (pc_advance_o),
    .flush_i      (flush_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] ipc;
  } vec_t;

  vec_t vec [20];

  function automatic vec_t mk(logic r, logic q, logic [15:0] a, logic v,
                              logic [15:0] i, logic [15:0] p);
    vec_t t;
    t.ready = r; t.req = q; t.addr = a; t.valid = v; t.instr = i; t.ipc = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample pre-edge request/advance, then update PC and memory.
  task automatic tick();
    logic        req;
    logic [15:0] a;
    logic        adv;
    req = imem_req_o;
    a   = imem_addr_o;
    adv = pc_advance_o;
    @(posedge clk);
    #1;
    imem_ack_i = 1'b0;
    if (req) begin
      mem_busy  = 1'b1;
      mem_cnt   = mem_lat;
      mem_paddr = a;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = use_ovr ? ovr_data : (16'hA000 + mem_paddr);
        mem_busy     = 1'b0;
      end
    end
    if (adv) pc_i = pc_i + 16'd1;
  endtask

  task automatic do_reset(input logic [15:0] pc);
    rst_n      = 1'b0;
    flush_i    = 1'b0;
    imem_ack_i = 1'b0;
    mem_busy   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pc_i = pc;
    #1;
    chk("rst_req",   imem_req_o,    0);
    chk("rst_addr",  imem_addr_o,   0);
    chk("rst_adv",   pc_advance_o,  0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o,       0);
    chk("rst_ipc",   instr_pc_o,    0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; pc_i = '0; flush_i = 1'b0; imem_ack_i = 1'b0;
    imem_rdata_i = '0; instr_ready_i = 1'b0;
    mem_lat = 1; mem_busy = 1'b0; mem_cnt = 0; mem_paddr = '0;
    use_ovr = 1'b0; ovr_data = '0;

    // Steady fetch from 0x0010, ready always high
    vec[0]  = mk(1, 1, 16'h0010, 0, 16'h0000, 16'h0000);
    vec[1]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    vec[2]  = mk(1, 1, 16'h0011, 1, 16'hA010, 16'h0010);
    vec[3]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    vec[4]  = mk(1, 1, 16'h0012, 1, 16'hA011, 16'h0011);
    vec[5]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    vec[6]  = mk(1, 1, 16'h0013, 1, 16'hA012, 16'h0012);
    // Wrap-around from 0x0030 with alternating ready (push+pop holds count)
    vec[7]  = mk(0, 1, 16'h0030, 0, 16'h0000, 16'h0000);
    vec[8]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    vec[9]  = mk(0, 1, 16'h0031, 1, 16'hA030, 16'h0030);
    vec[10] = mk(1, 0, 16'h0000, 1, 16'hA030, 16'h0030);
    vec[11] = mk(0, 1, 16'h0032, 1, 16'hA031, 16'h0031);
    vec[12] = mk(1, 0, 16'h0000, 1, 16'hA031, 16'h0031);
    vec[13] = mk(0, 1, 16'h0033, 1, 16'hA032, 16'h0032);
    vec[14] = mk(1, 0, 16'h0000, 1, 16'hA032, 16'h0032);
    vec[15] = mk(0, 1, 16'h0034, 1, 16'hA033, 16'h0033);
    vec[16] = mk(1, 0, 16'h0000, 1, 16'hA033, 16'h0033);
    vec[17] = mk(0, 1, 16'h0035, 1, 16'hA034, 16'h0034);
    vec[18] = mk(1, 0, 16'h0000, 1, 16'hA034, 16'h0034);
    vec[19] = mk(0, 1, 16'h0036, 1, 16'hA035, 16'h0035);

    for (int i = 0; i < 20; i++) begin
      if (i == 0) do_reset(16'h0010);
      if (i == 7) do_reset(16'h0030);
      instr_ready_i = vec[i].ready;
      #1;
      chk($sformatf("vec%0d_req", i), imem_req_o,   vec[i].req);
      chk($sformatf("vec%0d_adv", i), pc_advance_o, vec[i].req);
      if (vec[i].req) chk($sformatf("vec%0d_addr", i), imem_addr_o, vec[i].addr);
      chk($sformatf("vec%0d_valid", i), instr_valid_o, vec[i].valid);
      if (vec[i].valid) begin
        chk($sformatf("vec%0d_instr", i), instr_o,    vec[i].instr);
        chk($sformatf("vec%0d_ipc", i),   instr_pc_o, vec[i].ipc);
      end
      tick();
    end

    // Backpressure: two requests fill the buffer, then requests stop
    do_reset(16'h0040);
    instr_ready_i = 1'b0; mem_lat = 1;
    #1;
    chk("bp_req0", imem_req_o, 1);
    chk("bp_addr0", imem_addr_o, 16'h0040);
    tick(); #1;
    chk("bp_req1", imem_req_o, 0);
    tick(); #1;
    chk("bp_req2", imem_req_o, 1);
    chk("bp_addr2", imem_addr_o, 16'h0041);
    tick(); #1;
    chk("bp_req3", imem_req_o, 0);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk($sformatf("bp_stall%0d_req", k), imem_req_o, 0);
      chk($sformatf("bp_stall%0d_instr", k), instr_o, 16'hA040);
    end
    tick();
    instr_ready_i = 1'b1;
    #1;
    chk("bp_pop_req", imem_req_o, 0);
    chk("bp_pop_valid", instr_valid_o, 1);
    tick();
    instr_ready_i = 1'b0;
    #1;
    chk("bp_resume_req", imem_req_o, 1);
    chk("bp_resume_addr", imem_addr_o, 16'h0042);
    chk("bp_resume_instr", instr_o, 16'hA041);
    chk("bp_resume_ipc", instr_pc_o, 16'h0041);

    // Flush while waiting: response 0xBEEF must be dropped
    do_reset(16'h0020);
    instr_ready_i = 1'b1; mem_lat = 3; use_ovr = 1'b1; ovr_data = 16'hBEEF;
    #1;
    chk("fw_req0", imem_req_o, 1);
    chk("fw_addr0", imem_addr_o, 16'h0020);
    tick();
    flush_i = 1'b1;
    #1;
    chk("fw_flush_req", imem_req_o, 0);
    chk("fw_flush_adv", pc_advance_o, 0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("fw_drop_req", imem_req_o, 0);
    chk("fw_drop_valid", instr_valid_o, 0);
    tick(); #1;
    chk("fw_ack_seen", imem_ack_i, 1);
    chk("fw_ack_req", imem_req_o, 0);
    chk("fw_ack_valid", instr_valid_o, 0);
    mem_lat = 1; use_ovr = 1'b0;
    tick(); #1;
    chk("fw_next_req", imem_req_o, 1);
    chk("fw_next_addr", imem_addr_o, 16'h0021);
    chk("fw_next_valid", instr_valid_o, 0);
    tick(); #1;
    chk("fw_c5_valid", instr_valid_o, 0);
    tick(); #1;
    chk("fw_c6_valid", instr_valid_o, 1);
    chk("fw_c6_instr", instr_o, 16'hA021);
    chk("fw_c6_ipc", instr_pc_o, 16'h0021);

    // Flush coincident with ack
    do_reset(16'h0050);
    instr_ready_i = 1'b1; mem_lat = 2;
    #1;
    chk("fa_req0", imem_addr_o, 16'h0050);
    tick(); #1;
    chk("fa_wait_req", imem_req_o, 0);
    tick();
    flush_i = 1'b1;
    #1;
    chk("fa_ack_seen", imem_ack_i, 1);
    chk("fa_flush_req", imem_req_o, 0);
    chk("fa_flush_adv", pc_advance_o, 0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("fa_idle_valid", instr_valid_o, 0);
    chk("fa_idle_req", imem_req_o, 1);
    chk("fa_idle_addr", imem_addr_o, 16'h0051);
    tick(); #1;
    chk("fa_c4_valid", instr_valid_o, 0);
    tick(); tick(); #1;
    chk("fa_c6_valid", instr_valid_o, 1);
    chk("fa_c6_instr", instr_o, 16'hA051);

    // Async reset mid-WAIT with a buffered instruction
    do_reset(16'h0060);
    instr_ready_i = 1'b0; mem_lat = 1;
    #1;
    chk("ar_req0", imem_addr_o, 16'h0060);
    tick(); #1;
    mem_lat = 3;
    tick(); #1;
    chk("ar_req1", imem_addr_o, 16'h0061);
    chk("ar_instr1", instr_o, 16'hA060);
    tick(); #1;
    chk("ar_wait_valid", instr_valid_o, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_async_req",   imem_req_o,    0);
    chk("ar_async_addr",  imem_addr_o,   0);
    chk("ar_async_adv",   pc_advance_o,  0);
    chk("ar_async_valid", instr_valid_o, 0);
    chk("ar_async_instr", instr_o,       0);
    chk("ar_async_ipc",   instr_pc_o,    0);
    mem_busy = 1'b0; imem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pc_i = 16'h0070;
    rst_n = 1'b1;
    #1;
    chk("ar_after_req",  imem_req_o,   1);
    chk("ar_after_addr", imem_addr_o,  16'h0070);
    chk("ar_after_adv",  pc_advance_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Consumer of the program counter register's output: reads the current PC, issues one instruction-memory request per PC value, and buffers returned instructions for decode.
- Sits between the PC register and the decode stage.
- Signals the next-PC logic via a one-cycle advance pulse so the PC register loads its next value.
- Supports a flush from branch/redirect logic.

Parameters:
ADDR_W, 16, PC / instruction-memory address width
INSTR_W, 16, instruction word width
BUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
pc_i  in  ADDR_W  current PC from the PC register output
pc_advance_o  out  1  one-cycle pulse: PC consumed, next-PC logic may update
flush_i  in  1  discard buffered and in-flight instructions
imem_req_o  out  1  one-cycle request strobe to instruction memory
imem_addr_o  out  ADDR_W  request address, valid while imem_req_o=1
imem_ack_i  in  1  one-cycle response strobe, arrives >=1 cycle after request
imem_rdata_i  in  INSTR_W  response data, valid while imem_ack_i=1
instr_valid_o  out  1  buffer head valid
instr_o  out  INSTR_W  buffer head instruction
instr_pc_o  out  ADDR_W  address the head instruction was fetched from
instr_ready_i  in  1  decode accepts head when instr_valid_o & instr_ready_i

Behaviour:
- Reset: async on rst_n=0.
  - State IDLE, buffer count 0, read/write pointers 0.
  - imem_req_o=0, imem_addr_o=0, pc_advance_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0.
  - Reset mid-request: any later ack is ignored only if it arrives while in reset; after release, the bench guarantees no stale ack.
- FSM states: IDLE, WAIT (one request outstanding), DROP (outstanding request flushed, response to be discarded).
- IDLE:
  - A request issues when flush_i=0 and count < BUF_DEPTH. The outstanding request reserves a slot, so with count=BUF_DEPTH-1 a request is allowed only because no other request is outstanding.
  - Issue cycle (combinational outputs): imem_req_o=1, imem_addr_o=pc_i, pc_advance_o=1; the request address is latched. Next state WAIT.
- WAIT:
  - imem_ack_i=1 and flush_i=0: push {latched addr, imem_rdata_i} into the buffer; next state IDLE.
  - flush_i=1 and imem_ack_i=0: next state DROP.
  - flush_i=1 and imem_ack_i=1: data discarded; next state IDLE.
- DROP: imem_ack_i=1 -> discard, next state IDLE. flush_i in DROP is harmless.
- Buffer:
  - Circular, registered.
  - Head outputs are driven from the storage entry at the read pointer; instr_valid_o = (count!=0).
  - Pop on instr_valid_o & instr_ready_i.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo BUF_DEPTH.
  - Push never occurs when full, guaranteed by the reservation rule.
- Flush: on flush_i=1, count and pointers clear next edge and any same-cycle pop is ignored. No request or advance is issued in a flush cycle.
- Latency:
  - Request at cycle t, ack at t+N: instr_valid_o=1 at t+N+1.
  - Earliest next request is t+N+1, so peak throughput is 1 instruction per 2 cycles with N=1.
- pc_i is sampled only in issue cycles. The PC register updates on the edge after pc_advance_o.
- imem_ack_i in IDLE is a protocol violation: it is ignored and does not push.

Test Plan:
- Reset then steady fetch:
  - Setup: pc_i=0x0010 and increments after each advance; memory N=1 returns 0xA000+addr; instr_ready_i=1.
  - Required: requests at addrs 0x0010, 0x0011, 0x0012 every 2 cycles; instr_o=0xA010, 0xA011, 0xA012 with matching instr_pc_o; first instr_valid_o exactly 2 cycles after first imem_req_o.
- Backpressure:
  - Setup: instr_ready_i=0 and N=1.
  - Required: exactly 2 requests then imem_req_o stays 0 with count=2. After instr_ready_i=1 for one cycle, one pop, and the next request issues the following cycle.
- Flush while waiting:
  - Setup: flush_i pulsed at N=3, one cycle after a request to 0x0020; ack 0xBEEF arrives 2 cycles later.
  - Required: state goes to DROP; 0xBEEF is never presented; instr_valid_o=0; the next request issues the cycle after the ack.
- Flush coincident with ack:
  - Required: ack data dropped, buffer empty, state IDLE, no request in the flush cycle.
- Wrap-around:
  - Setup: 6 fetches with alternating ready.
  - Required: output order and instr_pc_o correct across pointer wrap; simultaneous push/pop keeps count.
- Async reset mid-WAIT:
  - Setup: rst_n low between edges.
  - Required: outputs go to reset values immediately, without waiting for a clock edge; after release, the first request uses the current pc_i.
